// File: rtl/pes_elevator_dispatcher_if.sv
// Request-side bundle between the call dispatcher and the car controller.
// The master is the dispatcher. The slave is the controller/button side that
// supplies calls, the car position and the completion handshake.
interface pes_elevator_dispatcher_if #(
  parameter int FLOORS = 8
);
  logic [FLOORS-1:0] call_btn;
  logic [FLOORS-1:0] car_floor;
  logic              complete;
  logic              hold;
  logic [FLOORS-1:0] request_floor;
  logic              req_valid;
  logic              dir;
  logic [FLOORS-1:0] pending;
  logic              busy;
  logic              timeout_alert;
  logic              floor_error;

  modport master (
    input  call_btn, car_floor, complete, hold,
    output request_floor, req_valid, dir, pending, busy, timeout_alert, floor_error
  );

  modport slave (
    output call_btn, car_floor, complete, hold,
    input  request_floor, req_valid, dir, pending, busy, timeout_alert, floor_error
  );
endinterface

// File: rtl/pes_elevator_dispatcher.sv
// SCAN call dispatcher. It latches button presses into a pending set and picks
// the next floor, keeping the current direction where possible. It issues the
// floor as a held one-hot request until the car reports completion, then waits
// out a door-dwell interval. A request that is never completed is abandoned
// after a timeout and re-selected later.
module pes_elevator_dispatcher #(
  parameter int FLOORS         = 8,
  parameter int DWELL_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  pes_elevator_dispatcher_if.master bus
);

  localparam int IDXW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_DWELL     = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNTW-1:0]   r_cnt;
  logic [FLOORS-1:0] r_pending;
  logic [FLOORS-1:0] r_request_floor;
  logic              r_req_valid;
  logic              r_dir;
  logic              r_busy;
  logic              r_timeout_alert;
  logic              r_floor_error;

  logic              w_onehot;
  logic [IDXW-1:0]   w_cur_idx;
  logic [FLOORS-1:0] w_above_mask;
  logic [FLOORS-1:0] w_below_mask;
  logic              w_above_found;
  logic [IDXW-1:0]   w_above_idx;
  logic              w_below_found;
  logic [IDXW-1:0]   w_below_idx;
  logic [IDXW-1:0]   w_sel_idx;
  logic              w_sel_dir;
  logic              w_dispatch;
  logic              w_done;
  logic [FLOORS-1:0] w_clr;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_onehot = (bus.car_floor != '0) &&
                    ((bus.car_floor & (bus.car_floor - FLOORS'(1))) == '0);

  // Encode the car position into an index (meaningful only when one-hot).
  always_comb begin
    w_cur_idx = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (bus.car_floor[i]) w_cur_idx = IDXW'(i);
    end
  end

  // Split outstanding calls into those strictly above and strictly below the car.
  genvar gi;
  generate
    for (gi = 0; gi < FLOORS; gi++) begin : g_split
      assign w_above_mask[gi] = r_pending[gi] && (gi > int'(w_cur_idx));
      assign w_below_mask[gi] = r_pending[gi] && (gi < int'(w_cur_idx));
    end
  endgenerate

  // Nearest call above (lowest index) and nearest call below (highest index).
  always_comb begin
    w_above_found = 1'b0;
    w_above_idx   = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (w_above_mask[i]) begin
        w_above_found = 1'b1;
        w_above_idx   = IDXW'(i);
      end
    end
    w_below_found = 1'b0;
    w_below_idx   = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (w_below_mask[i]) begin
        w_below_found = 1'b1;
        w_below_idx   = IDXW'(i);
      end
    end
  end

  // SCAN choice: serve the current floor, else keep going, else reverse.
  always_comb begin
    w_sel_idx = w_cur_idx;
    w_sel_dir = r_dir;
    if (r_pending[w_cur_idx]) begin
      w_sel_idx = w_cur_idx;
    end else if (r_dir) begin
      if (w_above_found) begin
        w_sel_idx = w_above_idx;
      end else begin
        w_sel_idx = w_below_idx;
        w_sel_dir = 1'b0;
      end
    end else begin
      if (w_below_found) begin
        w_sel_idx = w_below_idx;
      end else begin
        w_sel_idx = w_above_idx;
        w_sel_dir = 1'b1;
      end
    end
  end

  assign w_dispatch = (r_state == S_IDLE) && (r_pending != '0) && !bus.hold && w_onehot;
  assign w_done     = (r_state == S_WAIT_DONE) && bus.complete;
  // The served floor is masked in the completion cycle, so a simultaneous press there is dropped.
  assign w_clr      = w_done ? r_request_floor : '0;

  // Accumulate calls and flag a malformed car position one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending     <= '0;
      r_floor_error <= 1'b0;
    end else begin
      r_pending     <= (r_pending | bus.call_btn) & ~w_clr;
      r_floor_error <= !w_onehot;
    end
  end

  // Dispatch FSM: issue, wait for completion or timeout, then door dwell.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_request_floor <= '0;
      r_req_valid     <= 1'b0;
      r_dir           <= 1'b1;
      r_busy          <= 1'b0;
      r_timeout_alert <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dispatch) begin
            r_request_floor <= FLOORS'(1) << w_sel_idx;
            r_req_valid     <= 1'b1;
            r_dir           <= w_sel_dir;
            r_busy          <= 1'b1;
            r_cnt           <= '0;
            r_state         <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (bus.complete) begin
            r_request_floor <= '0;
            r_req_valid     <= 1'b0;
            r_cnt           <= '0;
            r_state         <= S_DWELL;
          end else if (r_cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the request; its pending bit stays set for re-selection.
            r_request_floor <= '0;
            r_req_valid     <= 1'b0;
            r_timeout_alert <= 1'b1;
            r_busy          <= 1'b0;
            r_cnt           <= '0;
            r_state         <= S_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        S_DWELL: begin
          if (r_cnt >= CNTW'(DWELL_CYCLES - 1)) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pending       = r_pending;
  assign bus.request_floor = r_request_floor;
  assign bus.req_valid     = r_req_valid;
  assign bus.dir           = r_dir;
  assign bus.busy          = r_busy;
  assign bus.timeout_alert = r_timeout_alert;
  assign bus.floor_error   = r_floor_error;

endmodule

// File: tb/tb_pes_elevator_dispatcher.sv
// Bench for pes_elevator_dispatcher. Each expected dispatch (floor, direction)
// is queued when the calls are driven. A monitor pops and compares it when
// req_valid rises. Direct checks cover reset, hold, timeout, floor errors and
// asynchronous reset.
module tb_pes_elevator_dispatcher;

  typedef struct {
    logic [7:0] floor;
    logic       dir;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic mon_prev_valid = 1'b0;

  pes_elevator_dispatcher_if #(.FLOORS(8)) bus ();

  pes_elevator_dispatcher #(
    .FLOORS(8),
    .DWELL_CYCLES(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: one line per dispatched request.
  always @(negedge clk) begin
    if (bus.req_valid === 1'b1 && !mon_prev_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_issue", bus.request_floor, 8'h00);
      end else begin
        mon_e = sb_q.pop_front();
        $display("issue floor=%02h dir=%0b (expected %02h/%0b)",
                 bus.request_floor, bus.dir, mon_e.floor, mon_e.dir);
        check_eq("issue_floor", bus.request_floor, mon_e.floor);
        check_eq("issue_dir", bus.dir, mon_e.dir);
      end
    end
    mon_prev_valid = (bus.req_valid === 1'b1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_issue(input logic [7:0] f, input logic d);
    exp_t e;
    e.floor = f;
    e.dir   = d;
    sb_q.push_back(e);
  endtask

  task automatic pulse_call(input logic [7:0] v);
    bus.call_btn = v;
    step();
    bus.call_btn = 8'h00;
  endtask

  task automatic wait_issue(input int max_cyc);
    int n = 0;
    while (bus.req_valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("issue_wait", bus.req_valid, 1);
  endtask

  task automatic complete_req();
    int n = 0;
    bus.complete = 1'b1;
    step();
    bus.complete = 1'b0;
    check_eq("done_valid", bus.req_valid, 0);
    while (bus.busy === 1'b1 && n < 10) begin
      step();
      n++;
    end
    check_eq("dwell_end", bus.busy, 0);
  endtask

  task automatic do_reset();
    int seen = 0;
    bus.call_btn  = 8'hFF;
    bus.car_floor = 8'h03;
    bus.complete  = 1'b1;
    bus.hold      = 1'b0;
    reset         = 1'b0;
    step();
    step();
    check_eq("rst_pending", bus.pending, 8'h00);
    check_eq("rst_req", bus.request_floor, 8'h00);
    check_eq("rst_valid", bus.req_valid, 0);
    check_eq("rst_dir", bus.dir, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_timeout", bus.timeout_alert, 0);
    check_eq("rst_ferr", bus.floor_error, 0);
    bus.call_btn  = 8'h00;
    bus.car_floor = 8'h80;
    bus.complete  = 1'b0;
    reset         = 1'b1;
    repeat (10) begin
      step();
      if (bus.req_valid !== 1'b0) seen++;
    end
    check_eq("rst_idle_no_issue", seen, 0);
  endtask

  initial begin
    int cnt;
    reset         = 1'b1;
    bus.call_btn  = 8'h00;
    bus.car_floor = 8'h80;
    bus.complete  = 1'b0;
    bus.hold      = 1'b0;
    #1;
    do_reset();

    // Single call from the top floor down to floor 0.
    expect_issue(8'h01, 1'b0);
    pulse_call(8'h01);
    check_eq("single_pending", bus.pending, 8'h01);
    check_eq("single_not_yet", bus.req_valid, 0);
    step();
    check_eq("single_valid", bus.req_valid, 1);
    check_eq("single_req", bus.request_floor, 8'h01);
    check_eq("single_dir", bus.dir, 0);
    bus.complete = 1'b1;
    step();
    bus.complete = 1'b0;
    check_eq("single_done_valid", bus.req_valid, 0);
    check_eq("single_cleared", bus.pending, 8'h00);
    check_eq("single_busy_dwell", bus.busy, 1);
    repeat (3) step();
    check_eq("single_busy_last", bus.busy, 1);
    step();
    check_eq("single_busy_fall", bus.busy, 0);

    // SCAN order from floor 3 going up with calls at 1, 5 and 7.
    do_reset();
    bus.car_floor = 8'h08;
    expect_issue(8'h20, 1'b1);
    expect_issue(8'h80, 1'b1);
    expect_issue(8'h02, 1'b0);
    pulse_call(8'hA2);
    check_eq("scan_pending", bus.pending, 8'hA2);
    wait_issue(5);
    bus.car_floor = 8'h20;
    complete_req();
    wait_issue(10);
    bus.car_floor = 8'h80;
    complete_req();
    wait_issue(10);
    check_eq("scan_reverse_dir", bus.dir, 0);
    bus.car_floor = 8'h02;
    complete_req();
    check_eq("scan_all_served", bus.pending, 8'h00);

    // Hold inhibits dispatch; release issues on the next cycle.
    bus.car_floor = 8'h01;
    bus.hold      = 1'b1;
    expect_issue(8'h10, 1'b1);
    pulse_call(8'h10);
    cnt = 0;
    repeat (20) begin
      step();
      if (bus.req_valid !== 1'b0) cnt++;
    end
    check_eq("hold_block", cnt, 0);
    bus.hold = 1'b0;
    step();
    check_eq("hold_release_valid", bus.req_valid, 1);
    check_eq("hold_release_req", bus.request_floor, 8'h10);
    complete_req();

    // Timeout: never complete, expect abandonment at T+64 and re-issue at T+65.
    bus.car_floor = 8'h01;
    expect_issue(8'h04, 1'b1);
    pulse_call(8'h04);
    wait_issue(5);
    expect_issue(8'h04, 1'b1);
    cnt = 0;
    repeat (63) begin
      step();
      if (bus.req_valid === 1'b1) cnt++;
    end
    check_eq("to_held_63", cnt, 63);
    check_eq("to_no_alert_yet", bus.timeout_alert, 0);
    step();
    check_eq("to_valid_drop", bus.req_valid, 0);
    check_eq("to_alert", bus.timeout_alert, 1);
    check_eq("to_pending_kept", bus.pending, 8'h04);
    step();
    check_eq("to_reissue", bus.req_valid, 1);
    check_eq("to_alert_sticky", bus.timeout_alert, 1);
    complete_req();
    check_eq("to_alert_after_done", bus.timeout_alert, 1);

    // Invalid car position blocks dispatch.
    bus.car_floor = 8'h03;
    pulse_call(8'h40);
    check_eq("ferr_multi", bus.floor_error, 1);
    check_eq("ferr_pending", bus.pending, 8'h40);
    repeat (3) step();
    check_eq("ferr_no_issue", bus.req_valid, 0);
    bus.car_floor = 8'h00;
    step();
    check_eq("ferr_zero", bus.floor_error, 1);
    check_eq("ferr_zero_no_issue", bus.req_valid, 0);
    expect_issue(8'h40, 1'b1);
    bus.car_floor = 8'h01;
    step();
    check_eq("ferr_clear", bus.floor_error, 0);
    check_eq("ferr_recover_issue", bus.req_valid, 1);
    pulse_call(8'h02);
    check_eq("wait_pending_add", bus.pending, 8'h42);
    check_eq("wait_req_stable", bus.request_floor, 8'h40);
    bus.car_floor = 8'h03;
    step();
    check_eq("wait_kept_on_ferr", bus.req_valid, 1);
    check_eq("wait_ferr", bus.floor_error, 1);

    // Asynchronous reset in the middle of WAIT_DONE, away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_valid", bus.req_valid, 0);
    check_eq("async_pending", bus.pending, 8'h00);
    check_eq("async_req", bus.request_floor, 8'h00);
    check_eq("async_busy", bus.busy, 0);
    check_eq("async_alert", bus.timeout_alert, 0);
    check_eq("async_dir", bus.dir, 1);
    check_eq("async_ferr", bus.floor_error, 0);
    bus.car_floor = 8'h01;
    step();
    reset = 1'b1;
    step();
    step();
    check_eq("post_reset_idle", bus.req_valid, 0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pes_elevator_dispatcher.md
# pes_elevator_dispatcher

Call-collection and dispatch block that drives the request side of the `pes_elevator` car controller. It latches one-hot hall/car button presses into a pending-call register. Using the car's reported floor, it picks the next target floor with a SCAN (keep-direction) policy. It issues that floor as a one-hot `request_floor`, holds it until the controller's `complete` handshake, then enforces a door-dwell interval before the next dispatch.

## Interface
Parameters:
- `FLOORS`, 8: number of floors; width of all one-hot floor vectors.
- `DWELL_CYCLES`, 4: cycles spent in DWELL after each completed request.
- `TIMEOUT_CYCLES`, 64: maximum cycles in WAIT_DONE before the request is abandoned.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `call_btn`  in  FLOORS  button pulses, one bit per floor; any number of bits per cycle.
- `car_floor`  in  FLOORS  one-hot current car floor, from the controller's `out_current_floor`.
- `complete`  in  1  level; the controller has reached the issued floor.
- `hold`  in  1  inhibits new dispatches; driven high during overweight or door-overtime.
- `request_floor`  out  FLOORS  one-hot target floor; 0 when `req_valid`=0.
- `req_valid`  out  1  `request_floor` is valid and held.
- `dir`  out  1  travel direction: 1 = up, 0 = down.
- `pending`  out  FLOORS  outstanding calls.
- `busy`  out  1  state is not IDLE.
- `timeout_alert`  out  1  sticky; set when a request times out.
- `floor_error`  out  1  registered; `car_floor` was not exactly one-hot in the previous cycle.

## Operation
- **Reset values** (applied while `reset`=0): `pending`=0, `request_floor`=0, `req_valid`=0, `dir`=1, `busy`=0, `timeout_alert`=0, `floor_error`=0, state=IDLE, dwell and timeout counters=0.
- **Call capture:** each cycle, `pending` <= (`pending` | `call_btn`) & ~clr. `clr` is the one-hot of the served floor in the cycle the request completes.
  - A press of the served floor in that same cycle is dropped, because the car is already there.
- **States:** IDLE, WAIT_DONE, DWELL.
- **IDLE → WAIT_DONE:** taken when `pending`≠0, `hold`=0 and `car_floor` is one-hot. On entry, `request_floor` <= selected floor, `req_valid` <= 1, `dir` updated.
- **Selection** (cur = index of the `car_floor` bit):
  - `pending[cur]` set: select cur; `dir` unchanged.
  - Else if `dir`=1: select the lowest pending index above cur. If none, select the highest pending index below cur and set `dir`=0.
  - Else if `dir`=0: select the highest pending index below cur. If none, select the lowest pending index above cur and set `dir`=1.
- **WAIT_DONE:**
  - `request_floor` is held stable. Changes to `pending` and `hold` do not alter it.
  - On `complete`=1: clear the served bit of `pending`, drop `req_valid` and `request_floor` to 0, then enter DWELL.
  - If the timeout counter reaches TIMEOUT_CYCLES with no `complete`:
    - drop `req_valid`;
    - set `timeout_alert`;
    - keep the pending bit set;
    - return to IDLE, so the call is re-selected.
- **DWELL:** count DWELL_CYCLES cycles, then go to IDLE. `complete` is ignored outside WAIT_DONE.
- **Invalid `car_floor`** (zero or multi-hot): `floor_error`=1 on the next cycle and no dispatch from IDLE. A request already in WAIT_DONE is kept.
- **Width:** counters are `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturate; they do not wrap.
- **Reset mid-operation:** all outputs return to their reset values immediately (asynchronously), including mid-WAIT_DONE. Pending calls are lost.

## Timing
- Button pulse in cycle N → `pending` bit set in N+1 → `req_valid`=1 in N+2, provided IDLE, `hold`=0 and a valid floor.
- `complete` high in cycle M (state WAIT_DONE) → in M+1: `req_valid`=0, bit cleared, state DWELL.
  - DWELL lasts cycles M+1 … M+DWELL_CYCLES; IDLE in M+DWELL_CYCLES+1.
  - Earliest next `req_valid` is M+DWELL_CYCLES+2.
- `hold` deasserted in cycle H (IDLE, pending≠0) → `req_valid`=1 in H+1.
- Timeout: `req_valid` first high in cycle T with no `complete` → in T+TIMEOUT_CYCLES: `req_valid`=0, `timeout_alert`=1. Re-issue no earlier than T+TIMEOUT_CYCLES+1.
- `busy` is registered with state: 1 in WAIT_DONE and DWELL.

## Test plan
- **Reset:** assert `reset`=0 with arbitrary inputs → `pending`=0, `request_floor`=0, `req_valid`=0, `dir`=1, all alerts 0. Release and idle 10 cycles → nothing issued.
- **Single call:**
  - Setup: `car_floor`=8'b1000_0000; `call_btn`=8'b0000_0001 for one cycle at N.
  - Expected at N+1: `pending`=8'h01.
  - Expected at N+2: `request_floor`=8'h01, `req_valid`=1, `dir`=0.
  - Then pulse `complete` at M → M+1: `req_valid`=0, `pending`=0. `busy` falls at M+5.
- **SCAN order:**
  - Setup: car at floor 3, `dir`=1, pending floors 1, 5 and 7.
  - Expected: first 8'h20. With car at 5, then 8'h80. With car at 7, then 8'h02 with `dir`=0.
- **Hold:**
  - `pending`=8'h10 with `hold`=1 for 20 cycles → `req_valid` stays 0.
  - Drop `hold` at H → `req_valid`=1, `request_floor`=8'h10 at H+1.
- **Timeout:**
  - Setup: request 8'h04 issued, `complete` never asserted.
  - Expected after 64 cycles: `timeout_alert`=1, `req_valid`=0, `pending`=8'h04.
  - Re-issued on the next cycle; `timeout_alert` stays set until reset.
- **Errors and reset mid-WAIT:**
  - `car_floor`=8'b0000_0011 with `pending`≠0 → `floor_error`=1, no issue.
  - Asserting `reset`=0 during WAIT_DONE → `req_valid`=0 and `pending`=0 immediately.
